// File: rtl/rom_reader.sv
// Streams a configurable address range out of a combinational ROM through a valid/ready port.
// Optional running checksum of transferred words when ROM_READER_CHECKSUM_EN is defined.
module rom_reader #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              loop,
   input  logic              stop,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
`ifdef ROM_READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

   state_t              state_q, state_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic [ADDR_W-1:0]   start_q, start_n;
   logic [ADDR_W-1:0]   end_q, end_n;
   logic                loop_q, loop_n;
   logic [DATA_W-1:0]   data_n;
   logic                valid_n;
   logic                busy_n;
   logic                done_n;
   logic                xfer_c;

   assign rom_addr = addr_q;
   assign xfer_c   = out_valid && out_ready;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         start_q   <= '0;
         end_q     <= '0;
         loop_q    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_n;
         addr_q    <= addr_n;
         start_q   <= start_n;
         end_q     <= end_n;
         loop_q    <= loop_n;
         out_data  <= data_n;
         out_valid <= valid_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state_q;
      addr_n  = addr_q;
      start_n = start_q;
      end_n   = end_q;
      loop_n  = loop_q;
      data_n  = out_data;
      valid_n = out_valid;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_n  = start_addr;
               start_n = start_addr;
               end_n   = end_addr;
               loop_n  = loop;
               state_n = RUN;
            end
         end
         RUN: begin
            // Output register free or being emptied this cycle: fetch the next word
            if (!out_valid || out_ready) begin
               data_n  = rom_data;
               valid_n = 1'b1;
               if (addr_q == end_q) begin
                  if (loop_q && !stop) begin
                     addr_n = start_q;
                  end else begin
                     addr_n  = addr_q + ADDR_W'(1);
                     state_n = DRAIN;
                  end
               end else begin
                  addr_n = addr_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (xfer_c) begin
               valid_n = 1'b0;
               state_n = FINISH;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
      done_n = (state_n == FINISH);
   end

`ifdef ROM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_n;

   // Running sum of accepted words, restarted by an honoured start
   always_comb begin
      sum_n = checksum;
      if (state_q == IDLE && start) begin
         sum_n = '0;
      end else if (xfer_c) begin
         sum_n = checksum + out_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else begin
         checksum <= sum_n;
      end
   end
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: scoreboard of expected words built per pass,
// popped and compared as each word transfers; timing and handshake checks per scenario.
module tb_rom_reader;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 4;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              loop;
   logic              stop;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;
`ifdef ROM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   logic [DATA_W-1:0] rom [8];
   assign rom_data = rom[rom_addr];

   rom_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .loop       (loop),
      .stop       (stop),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
`ifdef ROM_READER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] exp_sum;
   int  first_valid, last_xfer, done_at, n_xfer, stalls, stall_err;
   logic busy_early, done_after, busy_after;

   // Expected ROM word at an address: contents are 1..8 at addresses 0..7
   function automatic logic [DATA_W-1:0] model_word(input int a);
      return DATA_W'((a % 8) + 1);
   endfunction

   task automatic push_range(input int sa, input int ea, input int passes);
      int n;
      exp_q.delete();
      exp_sum = '0;
      n = ((ea - sa + 8) % 8) + 1;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_word((sa + i) % 8));
            exp_sum = exp_sum + model_word((sa + i) % 8);
         end
      end
   endtask

   // Drives one pass and scores each transferred word against exp_q
   task automatic run_pass(input string tag, input int sa, input int ea, input logic lp,
                           input bit stall, input int stop_words, input bit poke);
      int cyc;
      logic prev_stalled;
      logic [DATA_W-1:0] prev_data;
      logic [DATA_W-1:0] e;
      first_valid = -1; last_xfer = -1; done_at = -1; n_xfer = 0;
      stalls = 0; stall_err = 0; prev_stalled = 1'b0; prev_data = '0;
      start_addr = ADDR_W'(sa); end_addr = ADDR_W'(ea); loop = lp;
      stop = (stop_words == 0); out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; start_addr = '0; end_addr = '0; loop = 1'b0;
      cyc = 1;
      while (done_at < 0 && cyc < 300) begin
         out_ready = stall ? (cyc % 2 == 1) : 1'b1;
         if (cyc == 1) busy_early = busy;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (prev_stalled) begin
            stalls++;
            if (out_data !== prev_data) stall_err++;
         end
         prev_stalled = out_valid && !out_ready;
         prev_data = out_data;
         if (done === 1'b1) done_at = cyc;
         if (out_valid && out_ready) begin
            n_xfer++;
            last_xfer = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra_word got %0d want no word", tag, out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL %s_word%0d got %0d want %0d", tag, n_xfer, out_data, e);
               end
            end
         end
         if (stop_words > 0 && n_xfer >= stop_words) stop = 1'b1;
         start = (poke && cyc == 3);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; stop = 1'b0; out_ready = 1'b1;
      done_after = done;
      busy_after = busy;
      checks++;
      if (done_at < 0) begin
         errors++;
         $display("FAIL %s_done_timeout got no done want pulse within 300 cycles", tag);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_words got %0d left want 0", tag, exp_q.size());
      end
      checks++;
      if (done_after !== 1'b0 || busy_after !== 1'b0) begin
         errors++;
         $display("FAIL %s_after_done got done=%b busy=%b want 0 0", tag, done_after, busy_after);
      end
`ifdef ROM_READER_CHECKSUM_EN
      checks++;
      if (checksum !== exp_sum) begin
         errors++;
         $display("FAIL %s_checksum got %0d want %0d", tag, checksum, exp_sum);
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; loop = 1'b0; stop = 1'b0;
      start_addr = '0; end_addr = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got v=%b b=%b d=%b want 0 0 0", out_valid, busy, done);
      end
      checks++;
      if (rom_addr !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_regs got addr=%0d data=%0d want 0 0", rom_addr, out_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      push_range(2, 5, 1);
      run_pass("basic", 2, 5, 1'b0, 1'b0, -1, 1'b0);
      checks++;
      if (busy_early !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy got %b want 1", busy_early);
      end
      checks++;
      if (first_valid != 2) begin
         errors++;
         $display("FAIL basic_latency got %0d want 2", first_valid);
      end
      checks++;
      if (last_xfer - first_valid != 3 || n_xfer != 4) begin
         errors++;
         $display("FAIL basic_throughput got span=%0d n=%0d want 3 4", last_xfer - first_valid, n_xfer);
      end
      checks++;
      if (done_at != last_xfer + 1) begin
         errors++;
         $display("FAIL basic_done_time got %0d want %0d", done_at, last_xfer + 1);
      end
   endtask

   task automatic test_wrap();
      push_range(6, 1, 1);
      run_pass("wrap", 6, 1, 1'b0, 1'b0, -1, 1'b0);
      checks++;
      if (n_xfer != 4 || done_at != last_xfer + 1) begin
         errors++;
         $display("FAIL wrap_shape got n=%0d done=%0d want 4 %0d", n_xfer, done_at, last_xfer + 1);
      end
   endtask

   task automatic test_backpressure();
      push_range(0, 3, 1);
      run_pass("bp", 0, 3, 1'b0, 1'b1, -1, 1'b0);
      checks++;
      if (stalls == 0 || stall_err != 0) begin
         errors++;
         $display("FAIL bp_stable got stalls=%0d changes=%0d want >0 0", stalls, stall_err);
      end
      checks++;
      if (done_at != last_xfer + 1) begin
         errors++;
         $display("FAIL bp_done_time got %0d want %0d", done_at, last_xfer + 1);
      end
   endtask

   task automatic test_loop();
      push_range(4, 5, 2);
      run_pass("loop", 4, 5, 1'b1, 1'b0, 3, 1'b1);
      checks++;
      if (n_xfer != 4) begin
         errors++;
         $display("FAIL loop_count got %0d want 4", n_xfer);
      end
   endtask

   task automatic test_start_stop();
      push_range(4, 5, 1);
      run_pass("startstop", 4, 5, 1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (n_xfer != 2) begin
         errors++;
         $display("FAIL startstop_count got %0d want 2", n_xfer);
      end
   endtask

   task automatic test_single();
      push_range(7, 7, 1);
      run_pass("single", 7, 7, 1'b0, 1'b0, -1, 1'b0);
      checks++;
      if (n_xfer != 1 || first_valid != 2) begin
         errors++;
         $display("FAIL single_shape got n=%0d first=%0d want 1 2", n_xfer, first_valid);
      end
   endtask

   task automatic test_reset_midpass();
      start_addr = 3'd0; end_addr = 3'd7; loop = 1'b1; stop = 1'b0;
      out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midpass_active got v=%b b=%b want 1 1", out_valid, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midpass_async got v=%b b=%b d=%b want 0 0 0", out_valid, busy, done);
      end
      checks++;
      if (rom_addr !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL midpass_regs got addr=%0d data=%0d want 0 0", rom_addr, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1; loop = 1'b0; end_addr = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midpass_no_resume got v=%b b=%b want 0 0", out_valid, busy);
      end
      push_range(1, 2, 1);
      run_pass("postreset", 1, 2, 1'b0, 1'b0, -1, 1'b0);
      checks++;
      if (n_xfer != 2 || first_valid != 2) begin
         errors++;
         $display("FAIL postreset_shape got n=%0d first=%0d want 2 2", n_xfer, first_valid);
      end
   endtask

   initial begin
      rom = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_loop();
      test_start_stop();
      test_single();
      test_reset_midpass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_reader.md
ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning ROM address width (8 locations).
REQ-002 SHALL have parameter DATA_W, default 4, meaning ROM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a read pass; honoured only in IDLE.
REQ-006 SHALL have port loop  input  1  sampled at start; 1 = repeat the range until stop.
REQ-007 SHALL have port stop  input  1  level; in loop mode, ends looping after the current pass.
REQ-008 SHALL have port start_addr  input  ADDR_W  first address of range; sampled at start.
REQ-009 SHALL have port end_addr  input  ADDR_W  last address of range, inclusive; sampled at start.
REQ-010 SHALL have port rom_addr  output  ADDR_W  address driven to the combinational ROM.
REQ-011 SHALL have port rom_data  input  DATA_W  combinational ROM read data for rom_addr.
REQ-012 SHALL have port out_data  output  DATA_W  registered stream data.
REQ-013 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a pass sequence completes.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, FINISH.
REQ-018 IDLE: on start, SHALL latch start_addr into addr register and end_addr/loop into config registers, then enter RUN next cycle.
REQ-019 rom_addr SHALL equal the addr register at all times.
REQ-020 RUN: when out_valid==0 or a transfer occurs, SHALL load out_data<=rom_data, set out_valid<=1, and advance addr; otherwise SHALL hold all state (no data loss under backpressure).
REQ-021 Throughput SHALL be one word per cycle with out_ready held high; first out_valid SHALL appear 2 cycles after the start cycle.
REQ-022 addr SHALL increment modulo 2^ADDR_W; end_addr < start_addr SHALL wrap (e.g. 6,7,0,1); start_addr==end_addr SHALL emit exactly one word.
REQ-023 On loading the word at end_addr: if loop==1 and stop==0, SHALL reload addr<=start_addr and stay in RUN; otherwise SHALL enter DRAIN.
REQ-024 DRAIN: SHALL hold until the final word transfers, clearing out_valid, then enter FINISH.
REQ-025 FINISH: SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 start asserted while busy SHALL be ignored; start and stop together in IDLE SHALL begin a pass with stop taking effect at the first end_addr.
REQ-027 out_data SHALL remain stable while out_valid && !out_ready.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, addr 0, out_data 0, out_valid 0, busy 0, done 0, config registers 0, at any point including mid-pass; no partial pass resumes after release.

Configuration
REQ-029 With macro ROM_READER_CHECKSUM_EN defined, SHALL add output checksum (DATA_W) holding the modulo-2^DATA_W sum of all words transferred since the last start, cleared at start, valid when done pulses and held until next start; reset value 0.
REQ-030 Without ROM_READER_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour identical.

Verification (ROM holds 1,2,3,4,5,6,7,8 at addresses 0..7)
REQ-031 start, start_addr=2, end_addr=5, loop=0, out_ready=1 -> out_data 3,4,5,6 on consecutive cycles, done one cycle after last; checksum=2 (0x12 mod 16).
REQ-032 start_addr=6, end_addr=1 -> stream 7,8,1,2 (wrap), then done.
REQ-033 start_addr=0, end_addr=3, out_ready toggling 1/0 -> stream 1,2,3,4 with no drops or duplicates; out_data stable during stalls.
REQ-034 loop=1, range 4..5, stop raised after 3 words -> stream 5,6,5,6 then done; start while busy has no effect.
REQ-035 rst_n pulsed low mid-pass -> out_valid, busy, done drop to 0 immediately; next start runs a clean pass.
REQ-036 start_addr=end_addr=7 -> single word 8, then done.
